// File: rtl/div_pkg.sv
// Shared definitions for the iterative divider.
// Contents: divider FSM state enum, operand width, last iteration index.
package div_pkg;

    localparam int unsigned DIV_WIDTH     = 32;
    localparam int unsigned DIV_ITER_LAST = 31;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_CALC = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/div_abs.sv
// Combinational conditional two's-complement negate.
// Ports: i_data   - value in
//        i_neg    - 1 = return -i_data, 0 = pass through
//        o_data_c - result (combinational)
module div_abs #(
    parameter int unsigned W = 32
) (
    input  logic [W-1:0] i_data,
    input  logic         i_neg,
    output logic [W-1:0] o_data_c
);

    assign o_data_c = i_neg ? (~i_data + W'(1)) : i_data;

endmodule

// File: rtl/iter_div.sv
// Iterative radix-2 restoring divider, signed or unsigned per operation.
// Accepts a dividend/divisor pair on two stream slave channels (both valid
// in the same cycle) and returns {quotient, remainder} on a stream master.
// Ports: clk, reset (sync, active-high)
//        s_axis_dividend_* / s_axis_divisor_* - operand channels
//        div_signed  - two's-complement operation, sampled on accept
//        cancel      - abort the operation in flight
//        m_axis_dout_* - result channel, tdata = {quotient, remainder}
// Build option: ITER_DIV_ZERO_FAST_EN - a zero divisor completes in one
// cycle with quotient all-ones and remainder = dividend as given.
module iter_div
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [WIDTH-1:0]   s_axis_dividend_tdata,
    input  logic               s_axis_dividend_tvalid,
    output logic               s_axis_dividend_tready,
    input  logic [WIDTH-1:0]   s_axis_divisor_tdata,
    input  logic               s_axis_divisor_tvalid,
    output logic               s_axis_divisor_tready,
    input  logic               div_signed,
    input  logic               cancel,
    output logic [2*WIDTH-1:0] m_axis_dout_tdata,
    output logic               m_axis_dout_tvalid,
    input  logic               m_axis_dout_tready
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    div_state_e         r_state;
    div_state_e         w_state_nxt;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_quo;
    logic [WIDTH-1:0]   r_bmag;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_q_neg;
    logic               r_r_neg;
    logic [2*WIDTH-1:0] r_dout;
    logic               r_dout_valid;

    logic               w_ready;
    logic               w_accept;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic [WIDTH-1:0]   w_rem_sh;
    logic [WIDTH:0]     w_trial;
    logic               w_take;
    logic [WIDTH-1:0]   w_rem_step;
    logic [WIDTH-1:0]   w_quo_step;
    logic [WIDTH-1:0]   w_quo_fix;
    logic [WIDTH-1:0]   w_rem_fix;
    logic               w_last;
    logic               w_zero_div;

    // Ready depends only on state and reset, never on the valids.
    assign w_ready                = (r_state == DIV_IDLE) && !reset;
    assign s_axis_dividend_tready = w_ready;
    assign s_axis_divisor_tready  = w_ready;
    assign w_accept   = s_axis_dividend_tvalid && s_axis_divisor_tvalid && w_ready && !cancel;
    assign w_zero_div = (s_axis_divisor_tdata == '0);

    assign w_a_neg = div_signed && s_axis_dividend_tdata[WIDTH-1];
    assign w_b_neg = div_signed && s_axis_divisor_tdata[WIDTH-1];

    div_abs #(.W(WIDTH)) u_abs_a (.i_data(s_axis_dividend_tdata), .i_neg(w_a_neg), .o_data_c(w_a_mag));
    div_abs #(.W(WIDTH)) u_abs_b (.i_data(s_axis_divisor_tdata),  .i_neg(w_b_neg), .o_data_c(w_b_mag));

    // One restoring step. The bit shifted out of rem (r_rem MSB) means the
    // shifted value is >= 2^WIDTH > |b|, so the trial always succeeds then.
    assign w_rem_sh   = {r_rem[WIDTH-2:0], r_quo[WIDTH-1]};
    assign w_trial    = {1'b0, w_rem_sh} - {1'b0, r_bmag};
    assign w_take     = r_rem[WIDTH-1] || !w_trial[WIDTH];
    assign w_rem_step = w_take ? w_trial[WIDTH-1:0] : w_rem_sh;
    assign w_quo_step = {r_quo[WIDTH-2:0], w_take};
    assign w_last     = (r_cnt == CNT_W'(WIDTH - 1));

    div_abs #(.W(WIDTH)) u_abs_q (.i_data(w_quo_step), .i_neg(r_q_neg), .o_data_c(w_quo_fix));
    div_abs #(.W(WIDTH)) u_abs_r (.i_data(w_rem_step), .i_neg(r_r_neg), .o_data_c(w_rem_fix));

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= DIV_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; cancel overrides everything.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            DIV_IDLE: begin
                if (w_accept) begin
`ifdef ITER_DIV_ZERO_FAST_EN
                    w_state_nxt = w_zero_div ? DIV_DONE : DIV_CALC;
`else
                    w_state_nxt = DIV_CALC;
`endif
                end
            end
            DIV_CALC: begin
                if (w_last) begin
                    w_state_nxt = DIV_DONE;
                end
            end
            DIV_DONE: begin
                if (m_axis_dout_tready) begin
                    w_state_nxt = DIV_IDLE;
                end
            end
            default: w_state_nxt = DIV_IDLE;
        endcase
        if (cancel) begin
            w_state_nxt = DIV_IDLE;
        end
    end

    // Datapath and registered result.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rem        <= '0;
            r_quo        <= '0;
            r_bmag       <= '0;
            r_cnt        <= '0;
            r_q_neg      <= 1'b0;
            r_r_neg      <= 1'b0;
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
        end else begin
            if (w_accept) begin
                r_rem   <= '0;
                r_quo   <= w_a_mag;
                r_bmag  <= w_b_mag;
                r_cnt   <= '0;
                r_q_neg <= w_a_neg ^ w_b_neg;
                r_r_neg <= w_a_neg;
            end else if (r_state == DIV_CALC) begin
                r_rem <= w_rem_step;
                r_quo <= w_quo_step;
                r_cnt <= r_cnt + CNT_W'(1);
            end
            // Result captured only on entry to DONE, then held.
            if ((w_state_nxt == DIV_DONE) && (r_state != DIV_DONE)) begin
`ifdef ITER_DIV_ZERO_FAST_EN
                if (r_state == DIV_IDLE) begin
                    r_dout <= {{WIDTH{1'b1}}, s_axis_dividend_tdata};
                end else begin
                    r_dout <= {w_quo_fix, w_rem_fix};
                end
`else
                r_dout <= {w_quo_fix, w_rem_fix};
`endif
            end
            r_dout_valid <= (w_state_nxt == DIV_DONE);
        end
    end

    assign m_axis_dout_tdata  = r_dout;
    assign m_axis_dout_tvalid = r_dout_valid;

    // Only consulted by the zero-divisor fast path.
    logic w_unused;
    assign w_unused = w_zero_div;

endmodule

// File: tb/tb_iter_div.sv
// Directed self-checking bench for iter_div.
module tb_iter_div;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] dvd_data;
    logic        dvd_valid;
    logic        dvd_ready;
    logic [31:0] dvs_data;
    logic        dvs_valid;
    logic        dvs_ready;
    logic        sgn;
    logic        cancel;
    logic [63:0] dout_data;
    logic        dout_valid;
    logic        dout_ready;

    int n_vec = 0;
    int n_err = 0;

`ifdef ITER_DIV_ZERO_FAST_EN
    localparam int ZERO_LAT = 1;
`else
    localparam int ZERO_LAT = 33;
`endif

    iter_div dut (
        .clk                    (clk),
        .reset                  (reset),
        .s_axis_dividend_tdata  (dvd_data),
        .s_axis_dividend_tvalid (dvd_valid),
        .s_axis_dividend_tready (dvd_ready),
        .s_axis_divisor_tdata   (dvs_data),
        .s_axis_divisor_tvalid  (dvs_valid),
        .s_axis_divisor_tready  (dvs_ready),
        .div_signed             (sgn),
        .cancel                 (cancel),
        .m_axis_dout_tdata      (dout_data),
        .m_axis_dout_tvalid     (dout_valid),
        .m_axis_dout_tready     (dout_ready)
    );

    always #5 clk = ~clk;

    // Present a pair, hold until accepted (bounded); returns #1 after accept edge.
    task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                            output bit ok);
        int n;
        dvd_data = a; dvs_data = b; sgn = s;
        dvd_valid = 1'b1; dvs_valid = 1'b1;
        n = 0;
        while (!dvd_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        ok = dvd_ready;
        @(posedge clk); #1;
        dvd_valid = 1'b0; dvs_valid = 1'b0;
    endtask

    // Count cycles (accept cycle+1 = 1) until valid; notes any tready seen high.
    task automatic wait_valid(output int cyc, output bit rdy_seen);
        cyc = 1; rdy_seen = 0;
        while (!dout_valid && cyc < 100) begin
            if (dvd_ready || dvs_ready) rdy_seen = 1;
            @(posedge clk); #1; cyc++;
        end
        if (dvd_ready || dvs_ready) rdy_seen = 1;
    endtask

    task automatic take_result();
        dout_ready = 1'b1;
        @(posedge clk); #1;
        dout_ready = 1'b0;
    endtask

    // Watch for any unexpected valid over a window.
    task automatic watch_no_valid(input int cycles, output bit seen);
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            if (dout_valid) seen = 1;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_vec++; if (dvd_ready !== 1'b0 || dvs_ready !== 1'b0) begin n_err++;
            $display("FAIL reset_tready: got %b/%b expected 0/0", dvd_ready, dvs_ready); end
        n_vec++; if (dout_valid !== 1'b0) begin n_err++;
            $display("FAIL reset_valid: got %b expected 0", dout_valid); end
        n_vec++; if (dout_data !== 64'h0) begin n_err++;
            $display("FAIL reset_data: got %h expected 0", dout_data); end
        reset = 1'b0;
        @(posedge clk); #1;
        n_vec++; if (dvd_ready !== 1'b1 || dvs_ready !== 1'b1) begin n_err++;
            $display("FAIL post_reset_tready: got %b/%b expected 1/1", dvd_ready, dvs_ready); end
    endtask

    // Full operation with latency and tready checks.
    task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic s, input logic [63:0] exp, input int exp_lat);
        bit ok, rdy; int cyc;
        start_op(a, b, s, ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL %s_accept: tready never rose", name); end
        wait_valid(cyc, rdy);
        n_vec++; if (cyc !== exp_lat) begin n_err++;
            $display("FAIL %s_latency: got %0d expected %0d", name, cyc, exp_lat); end
        n_vec++; if (dout_data !== exp) begin n_err++;
            $display("FAIL %s_data: got %h expected %h", name, dout_data, exp); end
        n_vec++; if (rdy !== 1'b0) begin n_err++;
            $display("FAIL %s_busy_tready: tready seen 1 while busy, expected 0", name); end
        take_result();
        n_vec++; if (dout_valid !== 1'b0 || dvd_ready !== 1'b1) begin n_err++;
            $display("FAIL %s_after_hs: valid=%b tready=%b expected 0/1", name, dout_valid, dvd_ready); end
    endtask

    task automatic test_unsigned();
        run_op("u100_7", 32'd100, 32'd7, 1'b0, {32'h0000000E, 32'h00000002}, 33);
        run_op("uffff_16", 32'hFFFFFFFF, 32'h10, 1'b0, {32'h0FFFFFFF, 32'h0000000F}, 33);
    endtask

    task automatic test_signed();
        run_op("s_m7_2", 32'hFFFFFFF9, 32'd2, 1'b1, {32'hFFFFFFFD, 32'hFFFFFFFF}, 33);
        run_op("s_7_m2", 32'd7, 32'hFFFFFFFE, 1'b1, {32'hFFFFFFFD, 32'h00000001}, 33);
        run_op("s_min_m1", 32'h80000000, 32'hFFFFFFFF, 1'b1, {32'h80000000, 32'h00000000}, 33);
        run_op("s_m100_m7", 32'hFFFFFF9C, 32'hFFFFFFF9, 1'b1, {32'h0000000E, 32'hFFFFFFFE}, 33);
    endtask

    task automatic test_backpressure();
        bit ok, rdy, bad; int cyc; logic [63:0] exp;
        exp = {32'h00000006, 32'h00000002};
        start_op(32'd20, 32'd3, 1'b0, ok);
        wait_valid(cyc, rdy);
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (dout_valid !== 1'b1 || dout_data !== exp || dvd_ready !== 1'b0) bad = 1;
            @(posedge clk); #1;
        end
        n_vec++; if (bad || dout_data !== exp) begin n_err++;
            $display("FAIL bp_hold: got valid=%b data=%h expected 1 %h", dout_valid, dout_data, exp); end
        take_result();
        n_vec++; if (dvd_ready !== 1'b1 || dout_valid !== 1'b0) begin n_err++;
            $display("FAIL bp_release: tready=%b valid=%b expected 1/0", dvd_ready, dout_valid); end
    endtask

    task automatic test_div_zero();
        run_op("z_5_0", 32'd5, 32'd0, 1'b0, {32'hFFFFFFFF, 32'h00000005}, ZERO_LAT);
`ifdef ITER_DIV_ZERO_FAST_EN
        run_op("z_m5_0", 32'hFFFFFFFB, 32'd0, 1'b1, {32'hFFFFFFFF, 32'hFFFFFFFB}, ZERO_LAT);
`else
        run_op("z_m5_0", 32'hFFFFFFFB, 32'd0, 1'b1, {32'h00000001, 32'hFFFFFFFB}, ZERO_LAT);
`endif
    endtask

    task automatic test_cancel();
        bit ok, seen;
        start_op(32'd1000, 32'd7, 1'b0, ok);
        repeat (9) @(posedge clk);
        #1;
        cancel = 1'b1;
        @(posedge clk); #1;
        cancel = 1'b0;
        n_vec++; if (dvd_ready !== 1'b1) begin n_err++;
            $display("FAIL cancel_idle: tready=%b expected 1", dvd_ready); end
        watch_no_valid(40, seen);
        n_vec++; if (seen) begin n_err++;
            $display("FAIL cancel_no_result: valid seen 1 expected 0"); end
        run_op("c_9_3", 32'd9, 32'd3, 1'b0, {32'h00000003, 32'h00000000}, 33);
        // Cancel coinciding with both valids must block the accept.
        dvd_data = 32'd8; dvs_data = 32'd2; sgn = 1'b0;
        dvd_valid = 1'b1; dvs_valid = 1'b1; cancel = 1'b1;
        @(posedge clk); #1;
        dvd_valid = 1'b0; dvs_valid = 1'b0; cancel = 1'b0;
        n_vec++; if (dvd_ready !== 1'b1) begin n_err++;
            $display("FAIL cancel_accept: tready=%b expected 1", dvd_ready); end
        watch_no_valid(40, seen);
        n_vec++; if (seen) begin n_err++;
            $display("FAIL cancel_accept_result: valid seen 1 expected 0"); end
    endtask

    task automatic test_lone_valid();
        bit bad, rdy; int cyc;
        dvd_data = 32'd50; dvs_data = 32'd5; sgn = 1'b0;
        dvd_valid = 1'b1;
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (dvd_ready !== 1'b1) bad = 1;
        end
        n_vec++; if (bad) begin n_err++;
            $display("FAIL lone_not_consumed: tready dropped, expected 1"); end
        dvs_valid = 1'b1;
        @(posedge clk); #1;
        dvd_valid = 1'b0; dvs_valid = 1'b0;
        n_vec++; if (dvd_ready !== 1'b0) begin n_err++;
            $display("FAIL lone_join_accept: tready=%b expected 0", dvd_ready); end
        wait_valid(cyc, rdy);
        n_vec++; if (cyc !== 33 || dout_data !== {32'd10, 32'd0}) begin n_err++;
            $display("FAIL lone_result: got lat %0d data %h expected 33 %h", cyc, dout_data, {32'd10, 32'd0}); end
        take_result();
    endtask

    task automatic test_reset_mid();
        bit ok, seen;
        start_op(32'd77, 32'd3, 1'b0, ok);
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b1;
        #0;
        n_vec++; if (dvd_ready !== 1'b0) begin n_err++;
            $display("FAIL rst_mid_tready: tready=%b expected 0", dvd_ready); end
        @(posedge clk); #1;
        reset = 1'b0;
        #0;
        n_vec++; if (dout_valid !== 1'b0 || dvd_ready !== 1'b1) begin n_err++;
            $display("FAIL rst_mid_idle: valid=%b tready=%b expected 0/1", dout_valid, dvd_ready); end
        watch_no_valid(40, seen);
        n_vec++; if (seen) begin n_err++;
            $display("FAIL rst_mid_no_result: valid seen 1 expected 0"); end
    endtask

    task automatic test_back_to_back();
        bit ok, rdy; int cyc, total;
        total = 0;
        for (int k = 0; k < 2; k++) begin
            start_op(32'd45 + 32'(k), 32'd4, 1'b0, ok);
            wait_valid(cyc, rdy);
            total += cyc + 1;
            n_vec++; if (dout_data !== {32'd11, 32'(1 + k)}) begin n_err++;
                $display("FAIL b2b_data%0d: got %h expected %h", k, dout_data, {32'd11, 32'(1 + k)}); end
            take_result();
        end
        n_vec++; if (total !== 68) begin n_err++;
            $display("FAIL b2b_period: got %0d cycles expected 68", total); end
    endtask

    initial begin
        reset = 1'b1; dvd_data = '0; dvs_data = '0; dvd_valid = 1'b0; dvs_valid = 1'b0;
        sgn = 1'b0; cancel = 1'b0; dout_ready = 1'b0;
        #1;
        test_reset();
        test_unsigned();
        test_signed();
        test_backpressure();
        test_div_zero();
        test_cancel();
        test_lone_valid();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
